// File: rtl/tlp_flow_tx_pkg.sv
// Shared definitions for the transmit-side lane flow controller.
// Holds lane count, lane-index width and the one-hot top FSM encoding.
// No ports; imported by the interface, the arbiter and the top.
package tlp_flow_tx_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  typedef enum logic [4:0] {
    ST_RESET  = 5'b00001,
    ST_INIT   = 5'b00010,
    ST_IDLE   = 5'b00100,
    ST_ACTIVE = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

endpackage

// File: rtl/tlp_flow_tx_if.sv
// Lane-source and downstream bus bundle for tlp_flow_tx.
// Ports: fifo_empty/fifo_data/fifo_pop toward the FWFT lane FIFOs,
//        pause/cont/error_full from the receive FSM, data_out/valid_out/lane_out downstream.
interface tlp_flow_tx_if #(
  parameter int DATA_W = 6
);
  import tlp_flow_tx_pkg::*;

  logic [LANES-1:0]        fifo_empty;
  logic [LANES*DATA_W-1:0] fifo_data;
  logic [LANES-1:0]        fifo_pop;
  logic [LANES-1:0]        pause;
  logic [LANES-1:0]        cont;
  logic [LANES-1:0]        error_full;
  logic [DATA_W-1:0]       data_out;
  logic                    valid_out;
  logic [LANE_W-1:0]       lane_out;

  // slave: the flow controller itself
  modport slave (
    input  fifo_empty, fifo_data, pause, cont, error_full,
    output fifo_pop, data_out, valid_out, lane_out
  );

  // master: lane sources / receive FSM / downstream sink
  modport master (
    output fifo_empty, fifo_data, pause, cont, error_full,
    input  fifo_pop, data_out, valid_out, lane_out
  );

endinterface

// File: rtl/tlp_flow_tx_rr_arbiter4.sv
// Four-way round-robin arbiter: grants the first requester after pointer.
// Latency: purely combinational.
// Backpressure: none; requesters not granted simply wait for a later cycle.
// Ports: request[4], pointer[2] in; grant[4] one-hot, grant_idx[2], any_grant out.
module rr_arbiter4
  import tlp_flow_tx_pkg::*;
(
  input  logic [LANES-1:0]  request,
  input  logic [LANE_W-1:0] pointer,
  output logic [LANES-1:0]  grant,
  output logic [LANE_W-1:0] grant_idx,
  output logic              any_grant
);

  logic [LANE_W-1:0] cand;

  // Search pointer+1, +2, +3, +4 (wraps to pointer itself last).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = pointer;
    for (int k = 1; k <= LANES; k++) begin
      cand = pointer + LANE_W'(k);
      if (!any_grant && request[cand]) begin
        any_grant   = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlp_flow_tx.sv
// Transmit-side flow controller: drains four FWFT lane FIFOs round-robin, obeying pause/cont/error_full.
// Latency: pop in cycle N -> registered data_out/lane_out/valid_out in cycle N+1.
// Backpressure: paused or errored lanes are not popped; pause/error_full block pops in the cycle they assert.
// Ports: clk, reset (sync, active-high), init; bus (slave modport); paused_status, error_status, idle.
module tlp_flow_tx
  import tlp_flow_tx_pkg::*;
#(
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  tlp_flow_tx_if.slave      bus,
  output logic [LANES-1:0]  paused_status,
  output logic [LANES-1:0]  error_status,
  output logic              idle
);

  state_t            state;
  state_t            state_nxt;
  logic [LANE_W-1:0] rr;
  logic [LANES-1:0]  eligible;
  logic [LANES-1:0]  grant;
  logic [LANE_W-1:0] grant_idx;
  logic              any_grant;
  logic              pop_en;
  logic [LANES-1:0]  paused_nxt;
  logic [LANES-1:0]  error_nxt;

  // Live pause/error_full are folded in so a lane stops in the very cycle it is told to.
  assign eligible = ~bus.fifo_empty & ~paused_status & ~bus.pause
                  & ~error_status & ~bus.error_full;

  rr_arbiter4 u_arb (
    .request   (eligible),
    .pointer   (rr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign pop_en       = (state == ST_ACTIVE) && any_grant;
  assign bus.fifo_pop = pop_en ? grant : '0;

  // pause beats cont when both are high
  assign paused_nxt = bus.pause | (paused_status & ~bus.cont);
  assign error_nxt  = error_status | bus.error_full;

  always_comb begin
    state_nxt = state;
    if (init) begin
      state_nxt = ST_INIT;
    end else begin
      case (state)
        ST_RESET:  state_nxt = ST_RESET;
        ST_INIT:   state_nxt = ST_IDLE;
        ST_IDLE:   state_nxt = (&error_nxt) ? ST_ERROR
                             : (|eligible)  ? ST_ACTIVE : ST_IDLE;
        ST_ACTIVE: state_nxt = (&error_nxt) ? ST_ERROR
                             : (|eligible)  ? ST_ACTIVE : ST_IDLE;
        ST_ERROR:  state_nxt = ST_ERROR;
        default:   state_nxt = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_RESET;
      rr            <= LANE_W'(LANES - 1);
      paused_status <= '0;
      error_status  <= '0;
      idle          <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
      bus.lane_out  <= '0;
    end else begin
      state         <= state_nxt;
      idle          <= (state_nxt == ST_IDLE);
      bus.valid_out <= pop_en;
      if (pop_en) begin
        bus.data_out <= bus.fifo_data[grant_idx*DATA_W +: DATA_W];
        bus.lane_out <= grant_idx;
        rr           <= grant_idx;
      end
      if (state == ST_INIT) begin
        paused_status <= '0;
        error_status  <= '0;
        rr            <= LANE_W'(LANES - 1);
      end else begin
        paused_status <= paused_nxt;
        error_status  <= error_nxt;
      end
    end
  end

endmodule
